// File: rtl/protobuf_pkg.sv
// -----------------------------------------------------------------------------
// protobuf_pkg
// Shared definitions for the protobuf varint decoding path: default limits,
// the decoder state encoding and small datapath helpers.
//   VARINT_MAX_BYTES : longest legal varint (10 bytes covers a 64-bit value)
//   IDX_W            : default field-index width
//   varint_state_e   : decoder FSM states
//   zigzag_decode()  : maps zigzag-encoded unsigned value back to signed form
//   sat_inc4()       : 4-bit increment that sticks at 15
// -----------------------------------------------------------------------------
package protobuf_pkg;

    localparam int VARINT_MAX_BYTES = 10;
    localparam int IDX_W            = 10;

    typedef enum logic [1:0] {
        VD_IDLE  = 2'd0,
        VD_ACCUM = 2'd1,
        VD_HOLD  = 2'd2,
        VD_DRAIN = 2'd3
    } varint_state_e;

    // (v >> 1) ^ -(v & 1): undoes the zigzag sign folding
    function automatic logic [63:0] zigzag_decode(input logic [63:0] v);
        return (v >> 1) ^ (64'd0 - {63'd0, v[0]});
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        logic [3:0] r;
        if (v == 4'd15) begin
            r = 4'd15;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/varint_decoder.sv
// -----------------------------------------------------------------------------
// varint_decoder
// Decodes a stream of protobuf base-128 varints (LSB group first, bit 7 =
// continuation) into 64-bit values with a valid/ready result handshake.
// Encodings longer than MAX_BYTES, or whose last legal byte overflows 64 bits,
// are flagged with out_error and reported with out_data = 0; any excess bytes
// are drained until the terminating byte.
//
// Optional feature: define VARINT_ZIGZAG_EN to add the in_zigzag input. When
// the value sampled with the first byte is 1, the result is zigzag-decoded.
//
// Ports
//   clock_clk      : clock, rising edge
//   reset_reset_n  : asynchronous active-low reset
//   clr            : synchronous clear, highest priority, drops partial value
//   in_data        : encoded byte stream
//   in_index       : field index, sampled with the first byte of a varint
//   in_zigzag      : (VARINT_ZIGZAG_EN only) zigzag select, first byte only
//   in_valid/in_ready   : byte handshake
//   out_data       : decoded value
//   out_index      : index captured from the first byte
//   out_nbytes     : bytes consumed, saturating at 15
//   out_error      : overlong / overflowing encoding
//   out_valid/out_ready : result handshake
// -----------------------------------------------------------------------------
module varint_decoder #(
    parameter int IDX_W     = protobuf_pkg::IDX_W,
    parameter int MAX_BYTES = protobuf_pkg::VARINT_MAX_BYTES
) (
    input  logic             clock_clk,
    input  logic             reset_reset_n,
    input  logic             clr,
    input  logic [7:0]       in_data,
    input  logic [IDX_W-1:0] in_index,
`ifdef VARINT_ZIGZAG_EN
    input  logic             in_zigzag,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    output logic [63:0]      out_data,
    output logic [IDX_W-1:0] out_index,
    output logic [3:0]       out_nbytes,
    output logic             out_error,
    output logic             out_valid,
    input  logic             out_ready
);

    import protobuf_pkg::*;

    varint_state_e    state_r;
    varint_state_e    state_next_s;
    logic [63:0]      acc_r;
    logic [3:0]       count_r;
    logic             err_r;
    logic [IDX_W-1:0] idx_r;
    logic             in_ready_r;
`ifdef VARINT_ZIGZAG_EN
    logic             zz_r;
    logic             zz_sel_s;
`endif

    logic             first_s;
    logic             last_s;
    logic [3:0]       k_s;
    logic [4:0]       byte_num_s;
    logic [6:0]       shamt_s;
    logic [63:0]      acc_base_s;
    logic [63:0]      acc_next_s;
    logic             err_base_s;
    logic             err_next_s;
    logic [3:0]       count_next_s;
    logic [63:0]      result_s;
    logic             accept_s;

    assign in_ready = in_ready_r;
    assign accept_s = in_valid && in_ready_r;

    // Next accumulator/count/error/state and result for the byte on in_data
    always_comb begin
        first_s = (state_r == VD_IDLE);
        if (first_s) begin
            k_s        = 4'd0;
            acc_base_s = 64'd0;
            err_base_s = 1'b0;
            byte_num_s = 5'd1;
        end else begin
            k_s        = count_r;
            acc_base_s = acc_r;
            err_base_s = err_r;
            byte_num_s = {1'b0, count_r} + 5'd1;
        end
        // 7-bit shift amount: groups beyond bit 63 shift out entirely
        shamt_s = {3'd0, k_s} * 7'd7;
        last_s  = (int'(byte_num_s) == MAX_BYTES);

        if (state_r == VD_DRAIN) begin
            acc_next_s = acc_r;
            err_next_s = err_r;
        end else begin
            acc_next_s = acc_base_s | ({57'd0, in_data[6:0]} << shamt_s);
            // the last legal byte may only carry bit 0 and must terminate
            err_next_s = err_base_s |
                         (last_s && ((in_data[6:1] != 6'd0) || in_data[7]));
        end

        if (first_s) begin
            count_next_s = 4'd1;
        end else begin
            count_next_s = sat_inc4(count_r);
        end

        case (state_r)
            VD_IDLE, VD_ACCUM: begin
                if (!in_data[7]) begin
                    state_next_s = VD_HOLD;
                end else if (last_s) begin
                    state_next_s = VD_DRAIN;
                end else begin
                    state_next_s = VD_ACCUM;
                end
            end
            VD_DRAIN: begin
                if (!in_data[7]) begin
                    state_next_s = VD_HOLD;
                end else begin
                    state_next_s = VD_DRAIN;
                end
            end
            default: state_next_s = state_r;
        endcase

`ifdef VARINT_ZIGZAG_EN
        if (first_s) begin
            zz_sel_s = in_zigzag;
        end else begin
            zz_sel_s = zz_r;
        end
`endif
        if (err_next_s) begin
            result_s = 64'd0;
        end else begin
`ifdef VARINT_ZIGZAG_EN
            if (zz_sel_s) begin
                result_s = zigzag_decode(acc_next_s);
            end else begin
                result_s = acc_next_s;
            end
`else
            result_s = acc_next_s;
`endif
        end
    end

    // Decoder FSM with registered handshake and result outputs
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r    <= VD_IDLE;
            acc_r      <= 64'd0;
            count_r    <= 4'd0;
            err_r      <= 1'b0;
            idx_r      <= '0;
            in_ready_r <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= 64'd0;
            out_index  <= '0;
            out_nbytes <= 4'd0;
            out_error  <= 1'b0;
`ifdef VARINT_ZIGZAG_EN
            zz_r       <= 1'b0;
`endif
        end else if (clr) begin
            state_r    <= VD_IDLE;
            acc_r      <= 64'd0;
            count_r    <= 4'd0;
            err_r      <= 1'b0;
            in_ready_r <= 1'b1;
            out_valid  <= 1'b0;
        end else begin
            case (state_r)
                VD_IDLE, VD_ACCUM, VD_DRAIN: begin
                    if (accept_s) begin
                        state_r <= state_next_s;
                        acc_r   <= acc_next_s;
                        count_r <= count_next_s;
                        err_r   <= err_next_s;
                        if (first_s) begin
                            idx_r <= in_index;
`ifdef VARINT_ZIGZAG_EN
                            zz_r  <= in_zigzag;
`endif
                        end
                        if (state_next_s == VD_HOLD) begin
                            in_ready_r <= 1'b0;
                            out_valid  <= 1'b1;
                            out_data   <= result_s;
                            out_nbytes <= count_next_s;
                            out_error  <= err_next_s;
                            // first byte may also be the last one
                            if (first_s) begin
                                out_index <= in_index;
                            end else begin
                                out_index <= idx_r;
                            end
                        end
                    end
                end
                VD_HOLD: begin
                    if (out_ready) begin
                        state_r    <= VD_IDLE;
                        out_valid  <= 1'b0;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= VD_IDLE;
                    out_valid  <= 1'b0;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/varint_decoder.md
VARINT_DECODER -- requirements
Module: varint_decoder

Interface
REQ-001 The module SHALL have parameter IDX_W, default 10, giving the field-index width.
REQ-002 The module SHALL have parameter MAX_BYTES, default 10, giving the maximum legal varint length in bytes.
REQ-003 clock_clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset_reset_n  in  1  reset; asynchronous assert, active-low.
REQ-005 clr  in  1  synchronous clear; drops any partial value.
REQ-006 in_data  in  8  encoded varint byte stream from the serializer output FIFO.
REQ-007 in_index  in  IDX_W  field index; sampled on the first byte of each varint only.
REQ-008 in_valid  in  1  byte available.
REQ-009 in_ready  out  1  byte accepted when in_valid and in_ready are both high.
REQ-010 out_data  out  64  decoded value.
REQ-011 out_index  out  IDX_W  index captured from the first byte.
REQ-012 out_nbytes  out  4  number of bytes consumed for this value (1..15, saturating).
REQ-013 out_error  out  1  overlong or overflowing encoding.
REQ-014 out_valid / out_ready  out / in  1 / 1  result handshake.

Function
REQ-015 The FSM SHALL have four states: IDLE, ACCUM, HOLD and DRAIN.
REQ-016 In IDLE, an accepted byte SHALL clear the accumulator, capture in_index, set count=1 and load bits [6:0] at accumulator offset 0.
REQ-017 The FSM SHALL go to HOLD if in_data[7]=0, else to ACCUM.
REQ-018 In ACCUM, the k-th accepted byte (k from 0) SHALL OR bits [6:0]<<7k into the accumulator; bits shifted past bit 63 SHALL be discarded.
REQ-019 in_ready SHALL be 1 in IDLE, ACCUM and DRAIN, and 0 in HOLD.
REQ-020 out_valid SHALL be 1 only in HOLD; it rises the cycle after the terminating byte is accepted (latency 1).
REQ-021 out_* SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 A HOLD cycle with out_ready=1 SHALL complete the transfer, and the next state SHALL be IDLE; no byte is accepted in that cycle.
REQ-023 Byte number MAX_BYTES with in_data[6:1]!=0 SHALL set the error flag.
REQ-024 Byte number MAX_BYTES with in_data[7]=1 SHALL set the error flag and go to DRAIN.
REQ-025 DRAIN SHALL consume bytes, with count saturating at 15, until a byte with bit7=0 is accepted, then go to HOLD.
REQ-026 When the error flag is set, out_data SHALL be 0 and out_error SHALL be 1; otherwise out_error SHALL be 0.
REQ-027 clr SHALL have priority over all other inputs: next state IDLE, out_valid 0 next cycle, accumulator, count and error cleared; a byte presented in the same cycle is not consumed.
REQ-028 The accumulator SHALL be the full 64 bits; no truncation SHALL occur before REQ-018 applies.

Reset
REQ-029 Reset assertion SHALL asynchronously force: state IDLE, out_valid=0, out_data=0, out_index=0, out_nbytes=0, out_error=0, accumulator=0, count=0.
REQ-030 After reset, in_ready SHALL be 1.
REQ-031 Reset mid-value SHALL discard the partial value without emitting any output.
REQ-032 Reset deassertion SHALL be assumed synchronized externally.

Configuration
REQ-033 With VARINT_ZIGZAG_EN defined, an input port in_zigzag (1 bit) SHALL exist and be sampled with the first byte.
REQ-034 When the sampled in_zigzag is 1, out_data SHALL be (acc>>1) XOR (0 - acc[0]), applied combinationally at the output register load with no added latency.
REQ-035 Without VARINT_ZIGZAG_EN, the in_zigzag port SHALL be absent and out_data SHALL be the raw accumulator.

Structure
REQ-036 Shared package protobuf_pkg SHALL hold VARINT_MAX_BYTES (10), IDX_W (10) and the decoder state enum.
REQ-037 The block SHALL be a single module with no sub-module; the shift/OR accumulator is inline.

Verification
REQ-038 Input 0x96,0x01 with index 5 -> out_data=150, out_nbytes=2, out_index=5, out_error=0, out_valid one cycle after the 2nd byte.
REQ-039 Input 0x00 -> out_data=0, out_nbytes=1; input 0xFF x9 then 0x01 -> out_data=0xFFFF_FFFF_FFFF_FFFF, out_nbytes=10, out_error=0.
REQ-040 Input 0xFF x10 then 0x00 -> DRAIN, out_error=1, out_data=0, out_nbytes=11; input 0xFF x9 then 0x02 -> out_error=1.
REQ-041 Input 0xAC,0x02 with out_ready held low for 5 cycles -> out_data=300 stable, in_ready=0 throughout, the next varint accepted only after the handshake.
REQ-042 Reset asserted, or clr pulsed, after 0x80,0x80 -> no output; a subsequent 0x01 -> out_data=1, out_nbytes=1.
REQ-043 With VARINT_ZIGZAG_EN, input 0x03 with in_zigzag=1 -> out_data=0xFFFF_FFFF_FFFF_FFFE (-2); input 0x04 -> out_data=2.
